// File: rtl/fpa_accumulator.sv
// Sequential reduction stage that sums a valid/ready stream of floating-point
// numbers using an external combinational fpa adder.
module fpa_accumulator #(
  parameter int EXP_SIZE    = 8,
  parameter int MANTIS_SIZE = 23,
  parameter int CNT_WIDTH   = 16,
  localparam int W          = 1 + EXP_SIZE + MANTIS_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [W-1:0]         in_data,
  input  logic                 in_last,
  output logic [W-1:0]         fpa_a,
  output logic [W-1:0]         fpa_b,
  input  logic [W-1:0]         fpa_result,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W-1:0]         out_sum,
  output logic [CNT_WIDTH-1:0] out_count,
  output logic [1:0]           dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid/data are held by the source until that edge.
  localparam logic [1:0] S_ACCEPT = 2'd0;
  localparam logic [1:0] S_ADD    = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  logic [1:0]           r_state;
  logic [W-1:0]         r_acc;
  logic [W-1:0]         r_op;
  logic                 r_last;
  logic [CNT_WIDTH-1:0] r_count;

  logic                 w_count_zero;
  logic                 w_count_sat;

  assign w_count_zero = (r_count == '0);
  assign w_count_sat  = (r_count == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_ACCEPT;
      r_acc   <= '0;
      r_op    <= '0;
      r_last  <= 1'b0;
      r_count <= '0;
    end else begin
      case (r_state)
        S_ACCEPT: begin
          if (in_valid) begin
            r_op    <= in_data;
            r_last  <= in_last;
            r_state <= S_ADD;
          end
        end
        S_ADD: begin
          // First element bypasses the adder so -0.0 survives untouched.
          if (w_count_zero) begin
            r_acc <= r_op;
          end else begin
            r_acc <= fpa_result;
          end
          if (!w_count_sat) begin
            r_count <= r_count + CNT_WIDTH'(1);
          end
          r_state <= r_last ? S_DONE : S_ACCEPT;
        end
        S_DONE: begin
          if (out_ready) begin
            r_acc   <= '0;
            r_count <= '0;
            r_state <= S_ACCEPT;
          end
        end
        default: begin
          r_state <= S_ACCEPT;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == S_ACCEPT);
  assign out_valid = (r_state == S_DONE);
  assign fpa_a     = r_acc;
  assign fpa_b     = r_op;
  assign out_sum   = r_acc;
  assign out_count = r_count;
  assign dbg_state = r_state;

endmodule

// File: doc/fpa_accumulator.md
Name: fpa_accumulator

Overview:
- Sequential reduction stage placed directly upstream of the combinational fpa adder; it feeds fpa's two operand inputs and captures fpa's result every add cycle.
- Accepts a valid/ready stream of floating-point numbers terminated by a last flag.
- Sums the stream into a registered accumulator.
- Presents the final sum and an element count on a valid/ready output port.
- fpa is instantiated beside this block at the next level up.

Parameters:
EXP_SIZE, 8, exponent field width; must match fpa
MANTIS_SIZE, 23, mantissa field width; must match fpa
CNT_WIDTH, 16, width of element counter
(W = 1+EXP_SIZE+MANTIS_SIZE throughout)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  upstream number valid
in_ready  output  1  block can accept a number this cycle
in_data  input  W  number {sign, exp, mantissa}
in_last  input  1  in_data is the final element of the stream
fpa_a  output  W  operand A to fpa (accumulator)
fpa_b  output  W  operand B to fpa (captured operand)
fpa_result  input  W  fpa number_out, combinational from fpa_a/fpa_b
out_valid  output  1  sum available
out_ready  input  1  downstream accepts sum
out_sum  output  W  accumulated sum
out_count  output  CNT_WIDTH  elements summed, saturating

Behaviour:
- State machine has three states.
  - S_ACCEPT: in_ready=1. On in_valid: op_r<=in_data, last_r<=in_last, go to S_ADD. Without in_valid, stay.
  - S_ADD: in_ready=0. Update the accumulator (below), then go to S_DONE if last_r=1, else S_ACCEPT.
  - S_DONE: out_valid=1, in_ready=0. On out_ready: acc_r<=0, count_r<=0, go to S_ACCEPT. Otherwise hold.
- Accumulator update in S_ADD:
  - If count_r==0, acc_r<=op_r. This is a bypass so that a lone -0.0, or the first element, passes through exactly.
  - Otherwise acc_r<=fpa_result.
  - count_r<=count_r+1, saturating at all-ones (no wrap).
- fpa_a=acc_r and fpa_b=op_r are driven from registers at all times.
  - Operands are stable for the whole S_ADD cycle.
  - The combinational path runs acc_r/op_r -> fpa -> acc_r within one cycle.
- out_sum=acc_r and out_count=count_r are driven continuously. They are meaningful only while out_valid=1, and are held stable while out_valid=1 and out_ready=0.
- Reset values:
  - state=S_ACCEPT, acc_r=0 (+0.0), op_r=0, last_r=0, count_r=0.
  - Hence out_valid=0, in_ready=1, out_sum=0, out_count=0, fpa_a=fpa_b=0.
- Latency and throughput:
  - Each element takes 2 cycles (ACCEPT, ADD); maximum input rate is one element per 2 cycles.
  - out_valid rises 2 cycles after the handshake of the last element.
- in_valid while in_ready=0 is ignored; upstream holds data until in_ready.
- out_ready while out_valid=0 is ignored.
- NaN, infinity and rounding results are whatever fpa produces; no special handling here.
- Reset mid-stream or mid-output discards all partial state; the next cycle is S_ACCEPT with everything cleared.

Test Plan:
- Bench: real fpa instance, single precision.
- Stream 0x3F800000, 0x40000000, 0x3F000000(last) with in_valid held high -> in_ready pattern 1,0,1,0,1,0; out_valid 2 cycles after last handshake; out_sum=0x40600000 (3.5), out_count=3.
- Single element 0x80000000 (-0.0) with last -> out_sum=0x80000000 (bypass, no fpa add), out_count=1.
- Backpressure: after done, hold out_ready=0 for 5 cycles -> out_valid=1, out_sum and out_count unchanged, in_ready=0 throughout. Assert out_ready=1 -> next cycle out_valid=0, in_ready=1, out_sum=0.
- Reset mid-stream: feed 0x3F800000, 0x40000000 (no last), pulse rst 1 cycle -> next cycle in_ready=1, out_sum=0, out_count=0. Then 0x40400000(last) -> out_sum=0x40400000, out_count=1.
- Special values: 0x7F800000 then 0xFF800000(last) -> out_sum equals the fpa_result pattern for inf+(-inf) sampled in the ADD cycle (NaN); out_count=2.
- Gapped input: 0x40000000, idle 3 cycles, 0x40000000(last) -> block stays in S_ACCEPT with acc_r=0x40000000 during the gap; out_sum=0x40800000 (4.0).
